// File: rtl/cpu_debug_ctrl.sv
// 6502 run/halt/step debug controller with NMI halts and breakpoints.
// Define CPU_DEBUG_CYCCNT_EN to add the 24-bit fetch counter at 0x10-0x12.
module cpu_debug_ctrl #(
  parameter logic [7:0] REG_BASE  = 8'hC0,
  parameter int         NUM_BP    = 2,
  parameter int         NMI_WIDTH = 8,
  parameter int         STEP_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  A,
  input  logic        write,
  input  logic [7:0]  Din,
  output logic [7:0]  Dout,
  output logic        hit,
  input  logic [15:0] cpu_addr,
  input  logic        sync,
  input  logic        b_runhalt,
  input  logic        b_step,
  input  logic        b_reset,
  output logic        nmiN,
  output logic        stopped,
  output logic [1:0]  halt_cause
);

  typedef enum logic [1:0] {RUN, STOP, ARMED, WAIT} state_e;

  state_e state_q, state_d;
  logic              sync_q, runmode_q, runmode_d, first_q, first_d;
  logic [1:0]        cause_q, cause_d;
  logic [7:0]        nmi_q, dout_q, rd;
  logic [STEP_W-1:0] step_q, step_d, rem_q, rem_d;
  logic [NUM_BP-1:0] bp_en_q, bp_en_d;
  logic [NUM_BP-1:0][15:0] bp_q, bp_d;
  logic [15:0]       s16, sr16;
  logic [4:0]        off;
  logic              fetch, wr, ctrl_wr, stat_wr, bp_hit, nmi_req, resume;

  assign off        = A[4:0];
  assign hit        = (A[7:5] == REG_BASE[7:5]);
  assign wr         = write & hit;
  assign ctrl_wr    = wr && (off == 5'h02);
  assign stat_wr    = wr && (off == 5'h03);
  assign fetch      = sync & ~sync_q;
  assign nmiN       = (nmi_q == 8'd0);
  assign stopped    = (state_q == STOP);
  assign halt_cause = cause_q;
  assign Dout       = dout_q;
  assign sr16       = 16'(step_q);

  always_comb begin
    bp_hit = 1'b0;
    for (int i = 0; i < NUM_BP; i++)
      if (bp_en_q[i] && bp_q[i] == cpu_addr) bp_hit = 1'b1;
  end

`ifdef CPU_DEBUG_CYCCNT_EN
  logic [23:0] cyc_q;
  logic [15:0] cyc_lat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q     <= '0;
      cyc_lat_q <= '0;
    end else begin
      if (resume)
        cyc_q <= '0;
      else if (fetch && (state_q == RUN || state_q == WAIT)
               && cyc_q != 24'hFFFFFF)
        cyc_q <= cyc_q + 24'd1;
      // 0x10 read snapshots the upper bytes for a coherent 24-bit read
      if (hit && !write && off == 5'h10)
        cyc_lat_q <= cyc_q[23:8];
    end
  end
`endif

  always_comb begin
    step_d  = step_q;
    bp_en_d = bp_en_q;
    bp_d    = bp_q;
    s16     = sr16;
    if (wr) begin
      if (off == 5'h00) s16[7:0]  = Din;
      if (off == 5'h01) s16[15:8] = Din;
      if (off == 5'h04) bp_en_d   = Din[NUM_BP-1:0];
      for (int i = 0; i < NUM_BP; i++) begin
        if (off == 5'(8 + 2 * i)) bp_d[i][7:0]  = Din;
        if (off == 5'(9 + 2 * i)) bp_d[i][15:8] = Din;
      end
    end
    step_d = s16[STEP_W-1:0];
  end

  always_comb begin
    rd = 8'h00;
    if (off == 5'h00) rd = sr16[7:0];
    if (off == 5'h01) rd = sr16[15:8];
    if (off == 5'h03) rd = {stopped, cause_q, 5'b0};
    if (off == 5'h04) rd = 8'(bp_en_q);
    for (int i = 0; i < NUM_BP; i++) begin
      if (off == 5'(8 + 2 * i)) rd = bp_q[i][7:0];
      if (off == 5'(9 + 2 * i)) rd = bp_q[i][15:8];
    end
`ifdef CPU_DEBUG_CYCCNT_EN
    if (off == 5'h10) rd = cyc_q[7:0];
    if (off == 5'h11) rd = cyc_lat_q[7:0];
    if (off == 5'h12) rd = cyc_lat_q[15:8];
`endif
  end

  always_comb begin
    state_d   = state_q;
    runmode_d = runmode_q;
    cause_d   = cause_q;
    rem_d     = rem_q;
    first_d   = first_q;
    nmi_req   = 1'b0;
    resume    = 1'b0;
    if (stat_wr) cause_d = 2'd0;
    if (fetch) first_d = 1'b0;
    unique case (state_q)
      RUN: begin
        if (b_runhalt || b_step) begin
          state_d = STOP; nmi_req = 1'b1; cause_d = 2'd1;
        end else if (fetch && bp_hit && !first_q) begin
          state_d = STOP; nmi_req = 1'b1; cause_d = 2'd3;
        end
      end
      STOP: begin
        if (b_reset) begin
          state_d = RUN; resume = 1'b1;
        end else if (b_runhalt) begin
          state_d = ARMED; runmode_d = 1'b1;
        end else if (b_step) begin
          state_d = ARMED; runmode_d = 1'b0;
        end
      end
      ARMED: begin
        if (b_reset) begin
          state_d = RUN; resume = 1'b1;
        end else if (ctrl_wr) begin
          rem_d   = (step_q == '0) ? STEP_W'(1) : step_q;
          resume  = 1'b1;
          state_d = (runmode_q || Din[1]) ? RUN : WAIT;
        end
      end
      WAIT: begin
        if (b_reset) begin
          state_d = RUN; resume = 1'b1;
        end else if (fetch && !first_q) begin
          rem_d = rem_q - STEP_W'(1);
          if (bp_hit) begin
            state_d = STOP; nmi_req = 1'b1; cause_d = 2'd3;
          end else if (rem_q == STEP_W'(1)) begin
            state_d = STOP; nmi_req = 1'b1; cause_d = 2'd2;
          end
        end
      end
      default: state_d = RUN;
    endcase
    // first fetch after any resume is the RTI return
    if (resume) first_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      sync_q    <= 1'b0;
      runmode_q <= 1'b0;
      first_q   <= 1'b0;
      cause_q   <= 2'd0;
      nmi_q     <= 8'd0;
      dout_q    <= 8'h00;
      step_q    <= STEP_W'(1);
      rem_q     <= STEP_W'(1);
      bp_en_q   <= '0;
      bp_q      <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync;
      runmode_q <= runmode_d;
      first_q   <= first_d;
      cause_q   <= cause_d;
      step_q    <= step_d;
      rem_q     <= rem_d;
      bp_en_q   <= bp_en_d;
      bp_q      <= bp_d;
      if (hit) dout_q <= rd;
      if (nmi_req && nmi_q == 8'd0)
        nmi_q <= 8'(NMI_WIDTH);
      else if (nmi_q != 8'd0)
        nmi_q <= nmi_q - 8'd1;
    end
  end

endmodule

// File: doc/cpu_debug_ctrl.md
Name: cpu_debug_ctrl

Overview:
Parametrised successor to the monitor-side CPU run/halt/step controller for the 6502 target. Halts the CPU through a timed NMI pulse on a button press, after N instructions (multi-step), or on one of NUM_BP fetch-address breakpoints. Exposes a 32-byte register window to the monitor program through the CPU's zero-page bus. Sits beside the monitor ROM decode; its Dout is muxed in whenever `hit` is high.

Parameters:
REG_BASE, 8'hC0, window base; must be a multiple of 32; window is REG_BASE..REG_BASE+31
NUM_BP, 2, number of breakpoint comparators, range 1..4
NMI_WIDTH, 8, clocks nmiN is held low per request, range 1..255
STEP_W, 16, width of step counter and step register

Ports:
clk  in  1  system clock
rst_n  in  1  reset
A  in  8  CPU address low byte (zero-page window decode)
write  in  1  CPU write strobe for the window
Din  in  8  CPU write data
Dout  out  8  registered read data
hit  out  1  combinational: A inside window
cpu_addr  in  16  full CPU address bus, sampled at sync
sync  in  1  CPU SYNC (opcode fetch)
b_runhalt  in  1  one-clock button pulse
b_step  in  1  one-clock button pulse
b_reset  in  1  one-clock button pulse; aborts step/wait back to RUN
nmiN  out  1  active-low NMI to CPU
stopped  out  1  high in STOP state
halt_cause  out  2  0 none, 1 button, 2 step done, 3 breakpoint

Behaviour:
- One clock `clk`. Reset is asynchronous, active-low (`rst_n`). In reset: nmiN=1, stopped=0, Dout=0, halt_cause=0, step reg=1, BP_EN=0, BP addrs=0, state RUN.
- sync rising edge is detected in clk domain (1-clock registered compare); "fetch" = that cycle, cpu_addr sampled in the same cycle.
- NMI: a request loads a counter with NMI_WIDTH; nmiN=0 while counter non-zero. Request while counter non-zero: ignored.
- Register map (offset = A[4:0]): 0x0/0x1 STEP lo/hi (R/W; value 0 treated as 1); 0x2 CTRL (W: bit0 resume-step, bit1 resume-run; bit1 wins if both set; reads 0); 0x3 STATUS (R: {stopped, halt_cause, 5'b0}; any write clears halt_cause to 0); 0x4 BP_EN (R/W, bits [NUM_BP-1:0], upper bits read 0); 0x8+2i/0x9+2i BP i lo/hi (R/W, i<NUM_BP); unmapped offsets read 0, writes ignored.
- Dout updated on the clock after A is presented (1-cycle read latency); holds last value when hit=0.
- States: RUN, STOP, ARMED, WAIT.
- RUN: b_runhalt or b_step -> NMI, STOP, cause=1. Enabled breakpoint match at fetch (suppressed on first fetch after resume) -> NMI, STOP, cause=3.
- STOP: b_reset -> RUN. Else b_runhalt -> ARMED with run-mode flag set. Else b_step -> ARMED with run-mode flag clear. CTRL write alone does nothing in STOP.
- ARMED: b_reset -> RUN. CTRL write -> load remaining = STEP (0->1), clear fetch count; goes to RUN if run-mode flag or CTRL bit1, else WAIT.
- WAIT: b_reset -> RUN, no NMI. Each fetch decrements remaining after the first fetch (the RTI return fetch). On the fetch where remaining hits 0: NMI, STOP, cause=2. A breakpoint match on the same fetch takes priority: cause=3.
- Simultaneous button and CTRL write in ARMED: b_reset wins, then CTRL.
- Reset mid-NMI pulse: nmiN returns to 1 immediately.

Optional Feature:
CPU_DEBUG_CYCCNT_EN: adds a 24-bit fetch counter, cleared on every resume. It increments on each fetch while in RUN/WAIT, saturates at 24'hFFFFFF, and reads at 0x10/0x11/0x12 (lo..hi). Reads of 0x10 latch all 24 bits for coherent access. Without the macro, 0x10-0x12 read 0 and no counter logic exists.

Test Plan:
- Reset then b_runhalt pulse -> nmiN low exactly 8 clocks; stopped=1; STATUS read at 0xC3 = 8'hA0.
- STOP, b_step, write 0xC2=0x01 with STEP=1 -> NMI fires on 2nd sync rise; cause=2; STOP.
- STEP=0x0005, step+resume -> NMI on 6th sync rise; b_reset mid-WAIT instead -> RUN, no NMI.
- BP0=0x1234, BP_EN=1, run; fetch at 0x1234 -> NMI, cause=3; resume-run from 0x1234 -> no retrigger on first fetch.
- STEP=0 behaves as 1; write 0xC3 clears cause to 0; read of 0xC5-0xC7 returns 0.
- With CPU_DEBUG_CYCCNT_EN, 300 fetches after resume-run -> 0x10..0x12 = 2C,01,00.
